// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and baud divisor helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned UART_OVERSAMPLE = 16;
   localparam int unsigned UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_WAIT_HIGH
   } uart_rx_state_e;

   // Rounded clocks-per-tick divisor for a 16x oversampled line.
   function automatic int unsigned uart_clk_div(input int unsigned clk_freq,
                                                input int unsigned baud);
      return (clk_freq + baud * (UART_OVERSAMPLE / 2)) / (baud * UART_OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one-cycle pulse every CLK_DIV clocks.
// A synchronous clear reloads the counter so the first tick lands CLK_DIV clocks later.
module uart_baud_tick #(
   parameter int unsigned CLK_DIV = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   // Down-counter with registered tick on wrap.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q <= RELOAD;
         tick  <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q <= RELOAD;
         tick  <= 1'b1;
      end else begin
         cnt_q <= cnt_q - CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled UART receiver with mid-bit sampling and a one-entry
// valid/ready holding register. Define UART_RX_PARITY_EN to add a parity frame bit.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      RX,
   output logic [UART_DATA_BITS-1:0] DATA,
   output logic                      VALID,
   input  logic                      READY,
   output logic                      FRAME_ERR,
   output logic                      OVERRUN,
   output logic                      PARITY_ERR,
   output logic                      BUSY
);

   localparam int unsigned CLK_DIV = uart_clk_div(CLK_FREQ, BAUD);
   localparam int unsigned SCW     = $clog2(UART_OVERSAMPLE);
   localparam int unsigned BCW     = $clog2(UART_DATA_BITS);
   localparam logic [SCW-1:0] MID_CNT  = SCW'(UART_OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] END_CNT  = SCW'(UART_OVERSAMPLE - 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(UART_DATA_BITS - 1);

   if (CLK_DIV < 2 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_rx_core: CLK_DIV must be >= 2 and PARITY_ODD must be 0 or 1");
   end

   logic                      rx_meta, rx_s;
   logic                      tick, tick_clear_c;
   uart_rx_state_e            state_q, state_d;
   logic [SCW-1:0]            scnt_q, scnt_d;
   logic [BCW-1:0]            bcnt_q, bcnt_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      good_c, frame_err_c, load_c;
`ifdef UART_RX_PARITY_EN
   logic                      perr_q, perr_d, parity_err_c;
`endif

   // Two-flop synchroniser for the asynchronous line, idling high.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   // Tick phase restarts at every start edge so samples land mid-bit.
   assign tick_clear_c = (state_q == ST_IDLE);

   uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
      .clk   (CLK),
      .reset (RESET),
      .clear (tick_clear_c),
      .tick  (tick)
   );

   // State and frame datapath registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         scnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   // Next-state, sample counting and frame result strobes.
   always_comb begin
      state_d     = state_q;
      scnt_d      = scnt_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      good_c      = 1'b0;
      frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d       = perr_q;
      parity_err_c = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            scnt_d = '0;
            bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b0;
`endif
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (tick) begin
               if (scnt_q == MID_CNT) begin
                  scnt_d  = '0;
                  state_d = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  scnt_d = scnt_q + SCW'(1);
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (scnt_q == END_CNT) begin
                  scnt_d  = '0;
                  shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                  bcnt_d  = bcnt_q + BCW'(1);
                  if (bcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end
               end else begin
                  scnt_d = scnt_q + SCW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               if (scnt_q == END_CNT) begin
                  scnt_d  = '0;
                  perr_d  = rx_s ^ (^shift_q) ^ 1'(PARITY_ODD);
                  state_d = ST_STOP;
               end else begin
                  scnt_d = scnt_q + SCW'(1);
               end
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (scnt_q == END_CNT) begin
                  scnt_d = '0;
                  if (!rx_s) begin
                     frame_err_c = 1'b1;
                     state_d     = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                  end else if (perr_q) begin
                     parity_err_c = 1'b1;
                     state_d      = ST_IDLE;
`endif
                  end else begin
                     good_c  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  scnt_d = scnt_q + SCW'(1);
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new byte can replace the held one in the same cycle it is drained.
   assign load_c = good_c && (!VALID || READY);

   // Holding register, error pulses and busy flag.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         DATA      <= '0;
         VALID     <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         FRAME_ERR <= frame_err_c;
         OVERRUN   <= good_c && VALID && !READY;
         BUSY      <= (state_d != ST_IDLE);
         if (load_c) begin
            DATA  <= shift_q;
            VALID <= 1'b1;
         end else if (VALID && READY) begin
            VALID <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity error pulse, reported at the stop-bit sample.
   always_ff @(posedge CLK) begin
      if (RESET) PARITY_ERR <= 1'b0;
      else       PARITY_ERR <= parity_err_c;
   end
`else
   assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core at 50 MHz / 115200 baud (27 clocks per tick).
// Frames carry a parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

   localparam int unsigned TICK_CLKS = 27;
   localparam int unsigned BIT_CLKS  = 16 * TICK_CLKS;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif
   localparam int unsigned FRAME_CLKS = BIT_CLKS * FRAME_BITS;

   logic       clk_tb = 1'b0;
   logic       reset_tb;
   logic       rx;
   logic       ready;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;
   logic       busy;

   int total = 0;
   int bad   = 0;

   int unsigned cyc = 0;
   logic [7:0]  rx_q [$];
   int unsigned rx_t [$];
   int fe_cnt = 0;
   int ov_cnt = 0;
   int pe_cnt = 0;
   int vh_cnt = 0;

   always #5 clk_tb = ~clk_tb;

   uart_rx_core #(
      .CLK_FREQ   (50000000),
      .BAUD       (115200),
      .PARITY_ODD (0)
   ) dut (
      .CLK        (clk_tb),
      .RESET      (reset_tb),
      .RX         (rx),
      .DATA       (data),
      .VALID      (valid),
      .READY      (ready),
      .FRAME_ERR  (frame_err),
      .OVERRUN    (overrun),
      .PARITY_ERR (parity_err),
      .BUSY       (busy)
   );

   // Cycle counter for handshake timestamps.
   always @(posedge clk_tb) cyc <= cyc + 1;

   // Monitor: log accepted bytes and count pulses, sampled mid-cycle.
   always @(negedge clk_tb) begin
      if (valid === 1'b1 && ready === 1'b1) begin
         rx_q.push_back(data);
         rx_t.push_back(cyc);
      end
      if (valid === 1'b1)      vh_cnt++;
      if (frame_err === 1'b1)  fe_cnt++;
      if (overrun === 1'b1)    ov_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
   end

   initial begin
      repeat (150000) @(posedge clk_tb);
      $display("FAIL watchdog: run exceeded 150000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk_tb);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^b);
`endif
      send_bit(stop_bit);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_badpar(input logic [7:0] b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~^b);
      send_bit(1'b1);
   endtask
`endif

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk_tb);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk_tb);
         k++;
      end
   endtask

   task automatic test_reset();
      reset_tb = 1'b1;
      rx       = 1'b1;
      ready    = 1'b1;
      repeat (4) @(negedge clk_tb);
      total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
      total++; if ({frame_err, overrun, parity_err} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, parity_err});
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset_tb = 1'b0;
      repeat (4) @(negedge clk_tb);
      total++; if ({busy, valid} !== 2'b00) begin
         bad++; $display("FAIL post_reset_idle: busy,valid got %b want 00", {busy, valid});
      end
   endtask

   task automatic test_single();
      int n0, v0, e0;
      logic [7:0] got;
      n0 = rx_q.size(); v0 = vh_cnt; e0 = fe_cnt + ov_cnt + pe_cnt;
      ready = 1'b1;
      send_frame(8'h41, 1'b1);
      idle_bits(1);
      wait_rx(n0 + 1, 2000);
      total++; if (rx_q.size() !== n0 + 1) begin
         bad++; $display("FAIL single_count: got %0d bytes want %0d", rx_q.size() - n0, 1);
      end
      got = (rx_q.size() > n0) ? rx_q[n0] : 8'hxx;
      total++; if (got !== 8'h41) begin bad++; $display("FAIL single_data: got %h want 41", got); end
      total++; if (vh_cnt - v0 !== 1) begin
         bad++; $display("FAIL single_valid_width: got %0d cycles want 1", vh_cnt - v0);
      end
      total++; if (fe_cnt + ov_cnt + pe_cnt - e0 !== 0) begin
         bad++; $display("FAIL single_err_pulses: got %0d want 0", fe_cnt + ov_cnt + pe_cnt - e0);
      end
      total++; if ({busy, valid, data} !== {2'b00, 8'h41}) begin
         bad++; $display("FAIL single_after: busy,valid,data got %b,%b,%h want 0,0,41", busy, valid, data);
      end
   endtask

   task automatic test_back_to_back();
      int n0, e0;
      logic [7:0] exp [3];
      logic [7:0] got;
      int unsigned gap;
      exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
      n0 = rx_q.size(); e0 = fe_cnt + ov_cnt + pe_cnt;
      for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
      idle_bits(2);
      wait_rx(n0 + 3, 2000);
      total++; if (rx_q.size() !== n0 + 3) begin
         bad++; $display("FAIL b2b_count: got %0d bytes want 3", rx_q.size() - n0);
      end
      for (int i = 0; i < 3; i++) begin
         got = (rx_q.size() > n0 + i) ? rx_q[n0 + i] : 8'hxx;
         total++; if (got !== exp[i]) begin
            bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got, exp[i]);
         end
      end
      for (int i = 1; i < 3; i++) begin
         gap = (rx_q.size() > n0 + i) ? rx_t[n0 + i] - rx_t[n0 + i - 1] : 0;
         total++; if (gap !== FRAME_CLKS) begin
            bad++; $display("FAIL b2b_spacing[%0d]: got %0d clocks want %0d", i, gap, FRAME_CLKS);
         end
      end
      total++; if (fe_cnt + ov_cnt + pe_cnt - e0 !== 0) begin
         bad++; $display("FAIL b2b_err_pulses: got %0d want 0", fe_cnt + ov_cnt + pe_cnt - e0);
      end
   endtask

   task automatic test_glitch();
      int n0, f0, v0;
      n0 = rx_q.size(); f0 = fe_cnt; v0 = vh_cnt;
      rx = 1'b0;
      repeat (3 * TICK_CLKS) @(negedge clk_tb);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
      idle_bits(2);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
      total++; if (vh_cnt - v0 !== 0 || rx_q.size() !== n0) begin
         bad++; $display("FAIL glitch_valid: got %0d valid cycles want 0", vh_cnt - v0);
      end
      total++; if (fe_cnt - f0 !== 0) begin
         bad++; $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - f0);
      end
   endtask

   task automatic test_frame_err();
      int n0, f0;
      logic [7:0] got;
      n0 = rx_q.size(); f0 = fe_cnt;
      send_frame(8'h55, 1'b0);
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk_tb);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy: got %b want 1", busy); end
      repeat (BIT_CLKS) @(negedge clk_tb);
      total++; if (rx_q.size() !== n0 || fe_cnt - f0 !== 1) begin
         bad++; $display("FAIL frame_err_pulse: got %0d pulses %0d bytes want 1 pulse 0 bytes",
                         fe_cnt - f0, rx_q.size() - n0);
      end
      idle_bits(1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release_busy: got %b want 0", busy); end
      send_frame(8'h5A, 1'b1);
      idle_bits(1);
      wait_rx(n0 + 1, 2000);
      got = (rx_q.size() > n0) ? rx_q[n0] : 8'hxx;
      total++; if (got !== 8'h5A || rx_q.size() !== n0 + 1) begin
         bad++; $display("FAIL frame_err_recover: got %h (%0d bytes) want 5a (1 byte)", got, rx_q.size() - n0);
      end
      total++; if (fe_cnt - f0 !== 1) begin
         bad++; $display("FAIL frame_err_total: got %0d pulses want 1", fe_cnt - f0);
      end
   endtask

   task automatic test_overrun();
      int n0, o0, f0;
      n0 = rx_q.size(); o0 = ov_cnt; f0 = fe_cnt;
      ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle_bits(1);
      total++; if ({valid, data} !== {1'b1, 8'h11}) begin
         bad++; $display("FAIL overrun_hold: valid,data got %b,%h want 1,11", valid, data);
      end
      total++; if (ov_cnt - o0 !== 1) begin
         bad++; $display("FAIL overrun_pulse: got %0d pulses want 1", ov_cnt - o0);
      end
      total++; if (rx_q.size() !== n0 || fe_cnt - f0 !== 0) begin
         bad++; $display("FAIL overrun_side: got %0d accepts %0d frame errs want 0 0", rx_q.size() - n0, fe_cnt - f0);
      end
      #1 ready = 1'b1;
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL drain_before_edge: got %b want 1", valid); end
      @(posedge clk_tb);
      #1;
      total++; if ({valid, data} !== {1'b0, 8'h11}) begin
         bad++; $display("FAIL drain_after_edge: valid,data got %b,%h want 0,11", valid, data);
      end
      @(negedge clk_tb);
   endtask

   task automatic test_parity();
`ifdef UART_RX_PARITY_EN
      int n0, p0;
      logic [7:0] got;
      n0 = rx_q.size(); p0 = pe_cnt;
      ready = 1'b1;
      send_frame_badpar(8'h07);
      idle_bits(1);
      total++; if (pe_cnt - p0 !== 1 || rx_q.size() !== n0) begin
         bad++; $display("FAIL parity_bad: got %0d pulses %0d bytes want 1 0", pe_cnt - p0, rx_q.size() - n0);
      end
      send_frame(8'h07, 1'b1);
      idle_bits(1);
      wait_rx(n0 + 1, 2000);
      got = (rx_q.size() > n0) ? rx_q[n0] : 8'hxx;
      total++; if (got !== 8'h07 || pe_cnt - p0 !== 1) begin
         bad++; $display("FAIL parity_good: got %h with %0d pulses want 07 with 1", got, pe_cnt - p0);
      end
`else
      total++; if (pe_cnt !== 0 || parity_err !== 1'b0) begin
         bad++; $display("FAIL parity_tied: got %0d pulses, level %b want 0", pe_cnt, parity_err);
      end
`endif
   endtask

   task automatic test_reset_mid_frame();
      int n0, e0;
      ready = 1'b0;
      send_frame(8'h33, 1'b1);
      idle_bits(1);
      n0 = rx_q.size(); e0 = fe_cnt + ov_cnt + pe_cnt;
      total++; if ({valid, data} !== {1'b1, 8'h33}) begin
         bad++; $display("FAIL midreset_setup: valid,data got %b,%h want 1,33", valid, data);
      end
      rx = 1'b0;
      repeat (3 * BIT_CLKS) @(negedge clk_tb);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy: got %b want 1", busy); end
      reset_tb = 1'b1;
      rx       = 1'b1;
      repeat (3) @(negedge clk_tb);
      total++; if ({busy, valid, data} !== {2'b00, 8'h00}) begin
         bad++; $display("FAIL midreset_in_reset: busy,valid,data got %b,%b,%h want 0,0,00", busy, valid, data);
      end
      reset_tb = 1'b0;
      ready    = 1'b1;
      idle_bits(2);
      total++; if ({busy, valid} !== 2'b00 || rx_q.size() !== n0) begin
         bad++; $display("FAIL midreset_after: busy,valid got %b,%b bytes %0d want 0,0,0", busy, valid, rx_q.size() - n0);
      end
      total++; if (fe_cnt + ov_cnt + pe_cnt - e0 !== 0) begin
         bad++; $display("FAIL midreset_flags: got %0d pulses want 0", fe_cnt + ov_cnt + pe_cnt - e0);
      end
   endtask

   initial begin
      reset_tb = 1'b1;
      rx       = 1'b1;
      ready    = 1'b0;
      @(negedge clk_tb);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_parity();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
